// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered immediate generator for RV32I/RV64I instructions.
//            A valid/ready handshake on each side and a 2-entry skid buffer
//            give full throughput with a registered in_ready. Each accepted
//            instruction yields an XLEN-wide immediate, a format code and its
//            sideband tag, in strict FIFO order.
// Options  : define IMM_GEN_ILLEGAL_EN to compute and register out_illegal;
//            otherwise out_illegal is tied low and no detection logic exists.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
   parameter int XLEN  = 32,   // 32 or 64
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   // Major opcodes
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Format codes presented on out_fmt
   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;
   localparam logic [2:0] FMT_CSRZ  = 3'd7;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // main slot invalid
      ST_ONE   = 2'd1,   // main slot valid
      ST_FULL  = 2'd2    // main and skid slots valid
   } state_t;

   state_t            state;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic              is_shift;
   logic [31:0]       shamt;
   logic [31:0]       dec_raw;
   logic [2:0]        dec_fmt;
   logic [XLEN-1:0]   dec_imm;

   logic              accept;
   logic              drain;
   logic              load_main;
   logic              load_skid;
   logic              move_skid;

   logic [XLEN-1:0]   skid_imm;
   logic [2:0]        skid_fmt;
   logic [TAG_W-1:0]  skid_tag;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign is_shift = (opcode == OPC_OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

   // The shift-amount field widens to 6 bits on RV64; the 32-bit raw
   // immediate is sign-extended from its bit 31, which equals instr[31]
   // for sign-extended formats and is 0 for zero-extended ones.
   if (XLEN == 64) begin : g_xlen64
      assign shamt   = {26'd0, in_instr[25:20]};
      assign dec_imm = {{(XLEN-32){dec_raw[31]}}, dec_raw};
   end else begin : g_xlen32
      assign shamt   = {27'd0, in_instr[24:20]};
      assign dec_imm = dec_raw;
   end

   // Immediate and format decode of the instruction on the input port
   always_comb begin
      dec_raw = '0;
      dec_fmt = FMT_NONE;
      case (opcode)
         OPC_OP_IMM: begin
            if (is_shift) begin
               dec_fmt = FMT_SHAMT;
               dec_raw = shamt;
            end else begin
               dec_fmt = FMT_I;
               dec_raw = {{20{in_instr[31]}}, in_instr[31:20]};
            end
         end
         OPC_LOAD, OPC_JALR: begin
            dec_fmt = FMT_I;
            dec_raw = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OPC_STORE: begin
            dec_fmt = FMT_S;
            dec_raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OPC_BRANCH: begin
            dec_fmt = FMT_B;
            dec_raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OPC_JAL: begin
            dec_fmt = FMT_J;
            dec_raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_fmt = FMT_U;
            dec_raw = {in_instr[31:12], 12'b0};
         end
         OPC_SYSTEM: begin
            if (funct3[2]) begin
               dec_fmt = FMT_CSRZ;
               dec_raw = {27'd0, in_instr[19:15]};
            end
         end
         OPC_OP, OPC_MISC_MEM: begin
            dec_fmt = FMT_NONE;
            dec_raw = '0;
         end
         default: begin
            dec_fmt = FMT_NONE;
            dec_raw = '0;
         end
      endcase
   end

   // A flush cycle drops the offered input; a drain in that cycle still counts
   assign accept    = in_valid & in_ready & ~flush_i;
   assign drain     = out_valid & out_ready;
   assign load_main = accept & ((state == ST_EMPTY) | ((state == ST_ONE) & drain));
   assign load_skid = accept & (state == ST_ONE) & ~drain;
   assign move_skid = ~flush_i & (state == ST_FULL) & drain;

   // Occupancy FSM with registered out_valid and in_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else if (flush_i) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state     <= ST_ONE;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && !drain) begin
                  state     <= ST_FULL;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b0;
               end else if (!accept && drain) begin
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  state     <= ST_ONE;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   // Main and skid slot payloads; main holds steady unless loaded or refilled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_imm  <= '0;
         out_fmt  <= FMT_NONE;
         out_tag  <= '0;
         skid_imm <= '0;
         skid_fmt <= FMT_NONE;
         skid_tag <= '0;
      end else begin
         if (load_skid) begin
            skid_imm <= dec_imm;
            skid_fmt <= dec_fmt;
            skid_tag <= in_tag;
         end
         if (load_main) begin
            out_imm <= dec_imm;
            out_fmt <= dec_fmt;
            out_tag <= in_tag;
         end else if (move_skid) begin
            out_imm <= skid_imm;
            out_fmt <= skid_fmt;
            out_tag <= skid_tag;
         end
      end
   end

`ifdef IMM_GEN_ILLEGAL_EN
   logic dec_illegal;
   logic skid_illegal;

   // Flag opcodes with no legal immediate form and RV32 shifts with instr[25] set
   always_comb begin
      dec_illegal = 1'b0;
      case (opcode)
         OPC_OP_IMM:
            dec_illegal = is_shift && (XLEN == 32) && in_instr[25];
         OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_JAL,
         OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_OP, OPC_MISC_MEM:
            dec_illegal = 1'b0;
         default:
            dec_illegal = 1'b1;
      endcase
   end

   // Illegal flag travels with its entry through the skid buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_illegal  <= 1'b0;
         skid_illegal <= 1'b0;
      end else begin
         if (load_skid) begin
            skid_illegal <= dec_illegal;
         end
         if (load_main) begin
            out_illegal <= dec_illegal;
         end else if (move_skid) begin
            out_illegal <= skid_illegal;
         end
      end
   end
`else
   assign out_illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Directed self-checking bench for imm_gen_pipe. One XLEN=32 and
//            one XLEN=64 instance share the same input stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

`ifdef IMM_GEN_ILLEGAL_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_i;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_tag;
   logic        out_ready;

   logic        rdy32, val32, ill32;
   logic [31:0] imm32;
   logic [2:0]  fmt32;
   logic [31:0] tag32;
   logic        rdy64, val64, ill64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic [31:0] tag64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm32;
      logic [63:0] imm64;
      logic [2:0]  fmt32;
      logic [2:0]  fmt64;
      logic        ill32;
      logic        ill64;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(val32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
      .out_tag(tag32), .out_illegal(ill32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(val64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
      .out_tag(tag64), .out_illegal(ill64)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (val32 !== 1'b0) begin errors++; $display("FAIL reset_valid32: got %b expected 0", val32); end
      checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_ready32: got %b expected 1", rdy32); end
      checks++; if (imm32 !== 32'h0) begin errors++; $display("FAIL reset_imm32: got %h expected 0", imm32); end
      checks++; if (fmt32 !== 3'd0) begin errors++; $display("FAIL reset_fmt32: got %0d expected 0", fmt32); end
      checks++; if (tag32 !== 32'h0) begin errors++; $display("FAIL reset_tag32: got %h expected 0", tag32); end
      checks++; if (ill32 !== 1'b0) begin errors++; $display("FAIL reset_ill32: got %b expected 0", ill32); end
      checks++; if (val64 !== 1'b0 || rdy64 !== 1'b1 || imm64 !== 64'h0)
         begin errors++; $display("FAIL reset_dut64: got v=%b r=%b imm=%h expected 0 1 0", val64, rdy64, imm64); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // addi x1,x0,-1 with out_ready high: visible one edge after acceptance
   task automatic test_latency();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      in_tag    = 32'hA5A50001;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (val32 !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", val32); end
      checks++; if (imm32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL lat_imm32: got %h expected ffffffff", imm32); end
      checks++; if (fmt32 !== 3'd1) begin errors++; $display("FAIL lat_fmt: got %0d expected 1", fmt32); end
      checks++; if (tag32 !== 32'hA5A50001) begin errors++; $display("FAIL lat_tag: got %h expected a5a50001", tag32); end
      checks++; if (imm64 !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL lat_imm64: got %h expected all ones", imm64); end
      @(negedge clk);
      checks++; if (val32 !== 1'b0) begin errors++; $display("FAIL lat_drain: got %b expected 0", val32); end
   endtask

   // All immediate formats streamed back-to-back with out_ready held high
   task automatic test_immediates();
      logic e_ill32, e_ill64;
      vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0}; // addi -1
      vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 3'd3, 1'b0, 1'b0}; // beq -4
      vecs[2]  = '{32'h80000037, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0}; // lui
      vecs[3]  = '{32'h01F09093, 32'h0000001F, 64'h000000000000001F, 3'd6, 3'd6, 1'b0, 1'b0}; // slli 31
      vecs[4]  = '{32'h02009093, 32'h00000000, 64'h0000000000000020, 3'd6, 3'd6, 1'b1, 1'b0}; // slli 32
      vecs[5]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1}; // bad opcode
      vecs[6]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0}; // sw -4
      vecs[7]  = '{32'h0100006F, 32'h00000010, 64'h0000000000000010, 3'd5, 3'd5, 1'b0, 1'b0}; // jal +16
      vecs[8]  = '{32'h8002D073, 32'h00000005, 64'h0000000000000005, 3'd7, 3'd7, 1'b0, 1'b0}; // csrrwi zimm 5
      vecs[9]  = '{32'h00000073, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0}; // ecall
      vecs[10] = '{32'h002080B3, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0}; // add
      vecs[11] = '{32'h80012083, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 3'd1, 1'b0, 1'b0}; // lw -2048
      vecs[12] = '{32'h12345097, 32'h12345000, 64'h0000000012345000, 3'd4, 3'd4, 1'b0, 1'b0}; // auipc
      vecs[13] = '{32'h43F0D093, 32'h0000001F, 64'h000000000000003F, 3'd6, 3'd6, 1'b1, 1'b0}; // srai 63
      vecs[14] = '{32'h00C08067, 32'h0000000C, 64'h000000000000000C, 3'd1, 3'd1, 1'b0, 1'b0}; // jalr +12
      vecs[15] = '{32'h0FF0000F, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0}; // fence
      vecs[16] = '{32'h0010809B, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1}; // addiw
      vecs[17] = '{32'hFF9FF06F, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd5, 3'd5, 1'b0, 1'b0}; // jal -8
      out_ready = 1'b1;
      for (int i = 0; i <= NV; i++) begin
         if (i > 0) begin
            e_ill32 = vecs[i-1].ill32 & ILL_EN;
            e_ill64 = vecs[i-1].ill64 & ILL_EN;
            checks++; if (val32 !== 1'b1 || rdy32 !== 1'b1)
               begin errors++; $display("FAIL vec%0d_hs32: got v=%b r=%b expected 1 1", i-1, val32, rdy32); end
            checks++; if (imm32 !== vecs[i-1].imm32)
               begin errors++; $display("FAIL vec%0d_imm32: got %h expected %h", i-1, imm32, vecs[i-1].imm32); end
            checks++; if (fmt32 !== vecs[i-1].fmt32)
               begin errors++; $display("FAIL vec%0d_fmt32: got %0d expected %0d", i-1, fmt32, vecs[i-1].fmt32); end
            checks++; if (tag32 !== 32'h100 + 32'(i-1))
               begin errors++; $display("FAIL vec%0d_tag32: got %h expected %h", i-1, tag32, 32'h100 + 32'(i-1)); end
            checks++; if (ill32 !== e_ill32)
               begin errors++; $display("FAIL vec%0d_ill32: got %b expected %b", i-1, ill32, e_ill32); end
            checks++; if (imm64 !== vecs[i-1].imm64)
               begin errors++; $display("FAIL vec%0d_imm64: got %h expected %h", i-1, imm64, vecs[i-1].imm64); end
            checks++; if (fmt64 !== vecs[i-1].fmt64)
               begin errors++; $display("FAIL vec%0d_fmt64: got %0d expected %0d", i-1, fmt64, vecs[i-1].fmt64); end
            checks++; if (ill64 !== e_ill64 || tag64 !== 32'h100 + 32'(i-1))
               begin errors++; $display("FAIL vec%0d_ill_tag64: got %b %h expected %b %h", i-1, ill64, tag64, e_ill64, 32'h100 + 32'(i-1)); end
         end
         if (i < NV) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_tag   = 32'h100 + 32'(i);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      checks++; if (val32 !== 1'b0 || val64 !== 1'b0)
         begin errors++; $display("FAIL imm_drain: got %b %b expected 0 0", val32, val64); end
   endtask

   // Stall downstream, stream tags 1,2,3, then release
   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'd1;
      @(negedge clk);
      checks++; if (val32 !== 1'b1 || rdy32 !== 1'b1 || tag32 !== 32'd1)
         begin errors++; $display("FAIL bp_one: got v=%b r=%b tag=%0d expected 1 1 1", val32, rdy32, tag32); end
      in_instr = 32'h00200093; in_tag = 32'd2;
      @(negedge clk);
      checks++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0)
         begin errors++; $display("FAIL bp_full_ready: got %b %b expected 0 0", rdy32, rdy64); end
      checks++; if (tag32 !== 32'd1 || imm32 !== 32'd1)
         begin errors++; $display("FAIL bp_hold1: got tag=%0d imm=%h expected 1 1", tag32, imm32); end
      in_instr = 32'h00300093; in_tag = 32'd3;
      @(negedge clk);
      checks++; if (rdy32 !== 1'b0 || val32 !== 1'b1 || tag32 !== 32'd1 || imm32 !== 32'd1)
         begin errors++; $display("FAIL bp_stall: got r=%b v=%b tag=%0d imm=%h expected 0 1 1 1", rdy32, val32, tag32, imm32); end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (tag32 !== 32'd2 || imm32 !== 32'd2 || rdy32 !== 1'b1)
         begin errors++; $display("FAIL bp_out2: got tag=%0d imm=%h r=%b expected 2 2 1", tag32, imm32, rdy32); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (tag32 !== 32'd3 || imm32 !== 32'd3 || val32 !== 1'b1 || tag64 !== 32'd3)
         begin errors++; $display("FAIL bp_out3: got tag=%0d imm=%h v=%b expected 3 3 1", tag32, imm32, val32); end
      @(negedge clk);
      checks++; if (val32 !== 1'b0)
         begin errors++; $display("FAIL bp_drain: got %b expected 0", val32); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'h21;
      @(negedge clk);
      in_tag = 32'h22;
      @(negedge clk);
      checks++; if (rdy32 !== 1'b0)
         begin errors++; $display("FAIL fl_full: got ready %b expected 0", rdy32); end
      flush_i = 1'b1; in_tag = 32'h23;
      @(negedge clk);
      flush_i = 1'b0; in_valid = 1'b0;
      checks++; if (val32 !== 1'b0 || rdy32 !== 1'b1 || val64 !== 1'b0)
         begin errors++; $display("FAIL fl_full_out: got v=%b r=%b expected 0 1", val32, rdy32); end
      @(negedge clk);
      checks++; if (val32 !== 1'b0)
         begin errors++; $display("FAIL fl_dropped_full: got valid %b expected 0", val32); end
      // flush in ONE with a new input offered and a drain in progress
      in_valid = 1'b1; in_tag = 32'h24;
      @(negedge clk);
      flush_i = 1'b1; out_ready = 1'b1; in_tag = 32'h25;
      @(negedge clk);
      flush_i = 1'b0; in_valid = 1'b0;
      checks++; if (val32 !== 1'b0 || rdy32 !== 1'b1)
         begin errors++; $display("FAIL fl_one_out: got v=%b r=%b expected 0 1", val32, rdy32); end
      @(negedge clk);
      checks++; if (val32 !== 1'b0)
         begin errors++; $display("FAIL fl_dropped_one: got valid %b expected 0", val32); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 32'h77;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (val32 !== 1'b1 || tag32 !== 32'h77)
         begin errors++; $display("FAIL ar_pre: got v=%b tag=%h expected 1 77", val32, tag32); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (val32 !== 1'b0 || rdy32 !== 1'b1)
         begin errors++; $display("FAIL ar_handshake: got v=%b r=%b expected 0 1", val32, rdy32); end
      checks++; if (imm32 !== 32'h0 || fmt32 !== 3'd0 || tag32 !== 32'h0 || ill32 !== 1'b0)
         begin errors++; $display("FAIL ar_payload: got imm=%h fmt=%0d tag=%h ill=%b expected zeros", imm32, fmt32, tag32, ill32); end
      checks++; if (val64 !== 1'b0 || imm64 !== 64'h0)
         begin errors++; $display("FAIL ar_dut64: got v=%b imm=%h expected 0 0", val64, imm64); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (val32 !== 1'b0 || rdy32 !== 1'b1)
         begin errors++; $display("FAIL ar_post: got v=%b r=%b expected 0 1", val32, rdy32); end
   endtask

   initial begin
      rst_n     = 1'b0;
      flush_i   = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_tag    = 32'h0;
      out_ready = 1'b0;
      test_reset();
      test_latency();
      test_immediates();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked successor to the combinational immediate generator. Sits between fetch and decode/execute.
- Accepts one 32-bit instruction per cycle with a sideband tag (e.g. PC) and emits the XLEN-wide immediate, a format code and a tag.
- Generalised to XLEN 32/64 and to the full RV32I/RV64I immediate set, including shift amounts and CSR zimm.
- Uses a 2-entry skid buffer, giving full throughput with a registered in_ready.

Parameters:
- XLEN, 32, data width of out_imm; legal values 32 or 64.
- TAG_W, 32, width of the tag carried alongside each instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; drops all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept (registered).
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  0=none/R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=CSR-Z.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  opcode/encoding has no legal immediate form.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_imm=0, out_fmt=0, out_tag=0, out_illegal=0, in_ready=1, state EMPTY.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: an instruction accepted at edge N is visible on out_* after edge N when the main slot is empty or drains that same cycle.
- States:
  - EMPTY: main slot invalid.
  - ONE: main slot valid.
  - FULL: main and skid slots valid.
- Transitions:
  - EMPTY --in--> ONE.
  - ONE with in & out --> ONE (new data loads into main).
  - ONE with in & !out --> FULL (new data loads into skid).
  - ONE with !in & out --> EMPTY.
  - FULL with out --> ONE (skid moves to main).
  - All other cases hold the current state.
- in_ready is registered: 1 in EMPTY and ONE, 0 in FULL. No input is accepted in FULL.
- Output stability: while out_valid & !out_ready, out_imm, out_fmt, out_tag and out_illegal are held stable. Ordering is strict FIFO.
- Flush: flush_i=1 forces the state to EMPTY at the next edge. in_valid is ignored that cycle, and any output transfer in that cycle still counts. Flush has priority over all transitions.
- Immediate rules. Each result is sign-extended from bit 31 of the instruction to XLEN unless marked zero-extended.
  - OP-IMM, LOAD, JALR: I-type, imm = instr[31:20].
  - OP-IMM with funct3 001/101: fmt 6, imm = zero-extended shamt. XLEN=32 uses instr[24:20], and instr[25]=1 is illegal. XLEN=64 uses instr[25:20].
  - STORE: S-type, {instr[31:25], instr[11:7]}.
  - BRANCH: B-type, {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - JAL: J-type, {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - LUI, AUIPC: U-type, {instr[31:12], 12'b0}. For XLEN=64 this is also sign-extended from bit 31.
  - SYSTEM with funct3[2]=1: fmt 7, imm = zero-extended instr[19:15].
  - SYSTEM with funct3[2]=0, OP, MISC-MEM: fmt 0, imm 0.
  - Any other opcode: fmt 0, imm 0, illegal.
- Computation is combinational on the input and registered into whichever slot is being loaded.
- Reset mid-operation: all entries are discarded immediately. No partial output is allowed.

Optional Feature:
- Macro: IMM_GEN_ILLEGAL_EN.
- Defined: out_illegal is computed per the rules above and is registered with each entry.
- Undefined: out_illegal is tied to 0 and the illegal-detection logic is not compiled. Illegal encodings still produce fmt 0, imm 0 (shamt encodings with instr[25]=1 at XLEN=32 still produce fmt 6 with the 5-bit shamt). The port remains present.

Test Plan:
- XLEN=32, send 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, tag echoed.
- Send 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, out_fmt=3. Then send 0x80000037 (lui) with XLEN=64 -> out_imm=0xFFFFFFFF80000000, out_fmt=4.
- XLEN=32, IMM_GEN_ILLEGAL_EN defined:
  - 0x01F09093 (slli x1,x1,31) -> out_imm=0x1F, fmt 6, illegal 0.
  - 0x02009093 -> illegal 1.
  - opcode 0x7F -> illegal 1, imm 0.
- Backpressure: out_ready=0, stream tags 1,2,3 back-to-back.
  - in_ready falls after two transfers; tag 3 is held upstream.
  - out_tag=1 stays stable.
  - Raising out_ready yields tags 1,2,3 in order on consecutive cycles.
- In FULL, assert flush_i for one cycle -> next cycle out_valid=0, in_ready=1. The in_valid presented during the flush is dropped.
- Assert rst_n=0 asynchronously mid-stream while in ONE -> outputs go to reset values before the next clock edge, and in_ready=1.
